// File: rtl/exe_alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational I-type ALU.
// Define EXE_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead.
module exe_alu_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [DW-1:0] req0_op1_i,
    input  logic [DW-1:0] req0_op2_i,
    input  logic [IW-1:0] req0_inst_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [DW-1:0] req1_op1_i,
    input  logic [DW-1:0] req1_op2_i,
    input  logic [IW-1:0] req1_inst_i,
    output logic [DW-1:0] alu_op1_o,
    output logic [DW-1:0] alu_op2_o,
    output logic [IW-1:0] alu_inst_o,
    input  logic          alu_we_i,
    input  logic [DW-1:0] alu_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_id_o,
    output logic          rsp_we_o,
    output logic [DW-1:0] rsp_wdata_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic [IW-1:0] inst_q, inst_d;
    logic          gnt_id_q, gnt_id_d;
    logic          last_grant_q, last_grant_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic          rsp_we_q, rsp_we_d;
    logic [DW-1:0] rsp_wdata_q, rsp_wdata_d;
    logic          gnt0, gnt1;

    always_comb begin
`ifdef EXE_ARB_FIXED_PRIO_EN
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i & ~req0_valid_i;
`else
        // On contention the requester that did not win last time goes next.
        gnt0 = req0_valid_i & (~req1_valid_i | last_grant_q);
        gnt1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
`endif
    end

    assign req0_ready_o = (state_q == StIdle) & gnt0 & ~rst_i;
    assign req1_ready_o = (state_q == StIdle) & gnt1 & ~rst_i;

    // Zero operands outside EXEC so the ALU sees opcode 0 and stays quiet.
    assign alu_op1_o  = (state_q == StExec) ? op1_q  : '0;
    assign alu_op2_o  = (state_q == StExec) ? op2_q  : '0;
    assign alu_inst_o = (state_q == StExec) ? inst_q : '0;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_wdata_o = rsp_wdata_q;

    always_comb begin
        state_d      = state_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        inst_d       = inst_q;
        gnt_id_d     = gnt_id_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_we_d     = rsp_we_q;
        rsp_wdata_d  = rsp_wdata_q;
        case (state_q)
            StIdle: begin
                if (gnt0 | gnt1) begin
                    state_d      = StExec;
                    gnt_id_d     = gnt1;
                    last_grant_d = gnt1;
                    op1_d        = gnt1 ? req1_op1_i  : req0_op1_i;
                    op2_d        = gnt1 ? req1_op2_i  : req0_op2_i;
                    inst_d       = gnt1 ? req1_inst_i : req0_inst_i;
                end
            end
            StExec: begin
                state_d     = StResp;
                rsp_valid_d = 1'b1;
                rsp_id_d    = gnt_id_q;
                rsp_we_d    = alu_we_i;
                rsp_wdata_d = alu_wdata_i;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            op1_q        <= '0;
            op2_q        <= '0;
            inst_q       <= '0;
            gnt_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            inst_q       <= inst_d;
            gnt_id_q     <= gnt_id_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_we_q     <= rsp_we_d;
            rsp_wdata_q  <= rsp_wdata_d;
        end
    end

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// Self-checking bench for exe_alu_arbiter: directed scenarios plus randomized traffic
// checked against an arbitration/ALU reference model.
module tb_exe_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_op1_i, req0_op2_i, req0_inst_i;
    logic [31:0] req1_op1_i, req1_op2_i, req1_inst_i;
    logic [31:0] alu_op1_o, alu_op2_o, alu_inst_o;
    logic        alu_we_i;
    logic [31:0] alu_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_we_o;
    logic [31:0] rsp_wdata_o;

    int checks   = 0;
    int failures = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    exe_alu_arbiter #(.DW(32), .IW(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i), .req0_inst_i(req0_inst_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i), .req1_inst_i(req1_inst_i),
        .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_inst_o(alu_inst_o),
        .alu_we_i(alu_we_i), .alu_wdata_i(alu_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_we_o(rsp_we_o), .rsp_wdata_o(rsp_wdata_o)
    );

    // Behavioural I-type ALU: returns {we, wdata}; no write gives wdata 0.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] inst);
        logic [31:0] r;
        logic        we;
        we = 1'b1;
        r  = '0;
        if (inst[6:0] != 7'h13) we = 1'b0;
        else begin
            case (inst[14:12])
                3'd0: r = a + b;
                3'd1: if (inst[31:25] == 7'h00) r = a << b[4:0]; else we = 1'b0;
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: begin
                    if (inst[31:25] == 7'h00) r = a >> b[4:0];
                    else if (inst[31:25] == 7'h20) r = $unsigned($signed(a) >>> b[4:0]);
                    else we = 1'b0;
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        if (!we) r = '0;
        return {we, r};
    endfunction

    assign {alu_we_i, alu_wdata_i} = alu_ref(alu_op1_o, alu_op2_o, alu_inst_o);

    function automatic int model_winner(input bit v0, input bit v1, input int last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef EXE_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    // Presents a request, waits (bounded) for a grant, then observes EXEC and RESP.
    task automatic transact(input bit v0, input bit v1,
                            input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] i0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] i1,
                            input int stall, input bit keep,
                            output bit ok, output int who, output bit both_hi,
                            output bit busy_rdy, output bit unstable,
                            output logic [31:0] e1, output logic [31:0] e2,
                            output logic [31:0] ei, output logic rv, output logic rid,
                            output logic rwe, output logic [31:0] rwd);
        ok = 0; who = -1; both_hi = 0; busy_rdy = 0; unstable = 0;
        e1 = 'x; e2 = 'x; ei = 'x; rv = 'x; rid = 'x; rwe = 'x; rwd = 'x;
        @(negedge clk);
        req0_valid_i = v0; req0_op1_i = a0; req0_op2_i = b0; req0_inst_i = i0;
        req1_valid_i = v1; req1_op1_i = a1; req1_op2_i = b1; req1_inst_i = i1;
        rsp_ready_i = (stall == 0);
        for (int i = 0; i < 8 && !ok; i++) begin
            #1;
            if (req0_ready_o && req1_ready_o) both_hi = 1;
            if (req0_ready_o) begin ok = 1; who = 0; end
            else if (req1_ready_o) begin ok = 1; who = 1; end
            @(negedge clk);
        end
        if (!ok) begin
            req0_valid_i = 0; req1_valid_i = 0; rsp_ready_i = 1;
            return;
        end
        if (!keep) begin
            if (who == 0) req0_valid_i = 0; else req1_valid_i = 0;
        end
        #1;
        e1 = alu_op1_o; e2 = alu_op2_o; ei = alu_inst_o;
        busy_rdy = busy_rdy | req0_ready_o | req1_ready_o;
        @(negedge clk);
        #1;
        rv = rsp_valid_o; rid = rsp_id_o; rwe = rsp_we_o; rwd = rsp_wdata_o;
        busy_rdy = busy_rdy | req0_ready_o | req1_ready_o;
        for (int k = 1; k <= stall; k++) begin
            @(negedge clk);
            if (k == stall) rsp_ready_i = 1;
            #1;
            if (rsp_valid_o !== rv || rsp_id_o !== rid || rsp_we_o !== rwe || rsp_wdata_o !== rwd)
                unstable = 1;
            busy_rdy = busy_rdy | req0_ready_o | req1_ready_o;
        end
    endtask

    task automatic test_reset();
        rst_i = 1; req0_valid_i = 1; req1_valid_i = 1; rsp_ready_i = 1;
        req0_op1_i = 32'h11; req0_op2_i = 32'h22; req0_inst_i = 32'h00500093;
        req1_op1_i = 32'h33; req1_op2_i = 32'h44; req1_inst_i = 32'h00500093;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready_o, req1_ready_o);
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_id_o !== 1'b0 || rsp_we_o !== 1'b0 || rsp_wdata_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp: got v=%b id=%b we=%b wd=%h expected all 0",
                     rsp_valid_o, rsp_id_o, rsp_we_o, rsp_wdata_o);
        end
        checks++;
        if (alu_op1_o !== 32'h0 || alu_op2_o !== 32'h0 || alu_inst_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_alu: got %h %h %h expected 0", alu_op1_o, alu_op2_o, alu_inst_o);
        end
        req0_valid_i = 0; req1_valid_i = 0; rst_i = 0;
        model_last = 1;
    endtask

    task automatic test_addi();
        bit ok, both, busy, unst; int who;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        transact(1, 0, 32'd3, 32'd5, 32'h00500093, 0, 0, 0, 0, 0,
                 ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
        checks++;
        if (!ok || who != 0) begin
            failures++; $display("FAIL addi_grant: got ok=%0d who=%0d expected 1/0", ok, who);
        end
        checks++;
        if (e1 !== 32'd3 || e2 !== 32'd5 || ei !== 32'h00500093) begin
            failures++; $display("FAIL addi_exec: got %h %h %h expected 3 5 00500093", e1, e2, ei);
        end
        checks++;
        if (rv !== 1'b1 || rid !== 1'b0 || rwe !== 1'b1 || rwd !== 32'd8) begin
            failures++;
            $display("FAIL addi_rsp: got v=%b id=%b we=%b wd=%h expected 1 0 1 8", rv, rid, rwe, rwd);
        end
        checks++;
        if (busy) begin failures++; $display("FAIL addi_busy_ready: got 1 expected 0"); end
        model_last = 0;
    endtask

    task automatic test_srai();
        bit ok, both, busy, unst; int who;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        transact(0, 1, 0, 0, 0, 32'h80000000, 32'd4, 32'h4040D093, 0, 0,
                 ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
        checks++;
        if (!ok || who != 1 || rv !== 1'b1 || rid !== 1'b1 || rwe !== 1'b1 || rwd !== 32'hF8000000) begin
            failures++;
            $display("FAIL srai_rsp: got who=%0d v=%b id=%b we=%b wd=%h expected 1 1 1 1 f8000000",
                     who, rv, rid, rwe, rwd);
        end
        model_last = 1;
    endtask

    task automatic test_contention();
        bit ok, both, busy, unst; int who, exp;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        for (int n = 0; n < 4; n++) begin
            exp = model_winner(1, 1, model_last);
            transact(1, 1, 32'd100, 32'd1, 32'h00100093, 32'd200, 32'd2, 32'h00200093, 0, 1,
                     ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
            checks++;
            if (!ok || who != exp || both || rid !== (exp == 1)) begin
                failures++;
                $display("FAIL contention_grant%0d: got who=%0d id=%b both=%0d expected who=%0d both=0",
                         n, who, rid, both, exp);
            end
            checks++;
            if (rwd !== ((exp == 1) ? 32'd202 : 32'd101) || rwe !== 1'b1) begin
                failures++;
                $display("FAIL contention_data%0d: got we=%b wd=%0d expected 1 %0d",
                         n, rwe, rwd, (exp == 1) ? 202 : 101);
            end
            model_last = exp;
        end
        req0_valid_i = 0; req1_valid_i = 0;
    endtask

    task automatic test_backpressure();
        bit ok, both, busy, unst; int who, exp;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        exp = model_winner(1, 1, model_last);
        transact(1, 1, 32'd7, 32'd9, 32'h0000C093, 32'd15, 32'd6, 32'h0000F093, 5, 1,
                 ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
        model_last = exp;
        checks++;
        if (!ok || who != exp || rv !== 1'b1 || unst || busy) begin
            failures++;
            $display("FAIL backpressure: got who=%0d v=%b unstable=%0d busy_ready=%0d expected %0d 1 0 0",
                     who, rv, unst, busy, exp);
        end
        checks++;
        if (rwd !== ((exp == 1) ? 32'd6 : 32'd14)) begin
            failures++; $display("FAIL backpressure_data: got %0d", rwd);
        end
        req0_valid_i = 0; req1_valid_i = 0;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++; $display("FAIL backpressure_release: got valid=%b expected 0", rsp_valid_o);
        end
        // Probe idle with a request that is withdrawn before the edge.
        req1_valid_i = 1; #1;
        checks++;
        if (req1_ready_o !== 1'b1) begin
            failures++; $display("FAIL backpressure_idle: got ready1=%b expected 1", req1_ready_o);
        end
        req1_valid_i = 0;
    endtask

    task automatic test_illegal();
        bit ok, both, busy, unst; int who;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        transact(1, 0, 32'h1234, 32'd3, 32'h02009093, 0, 0, 0, 0, 0,
                 ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
        checks++;
        if (!ok || rv !== 1'b1 || rid !== 1'b0 || rwe !== 1'b0 || rwd !== 32'h0) begin
            failures++;
            $display("FAIL illegal_slli: got ok=%0d v=%b id=%b we=%b wd=%h expected 1 1 0 0 0",
                     ok, rv, rid, rwe, rwd);
        end
        model_last = 0;
    endtask

    task automatic test_reset_exec();
        bit ok, both, busy, unst; int who; bit bad;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        @(negedge clk);
        req0_valid_i = 1; req0_op1_i = 32'd1; req0_op2_i = 32'd2; req0_inst_i = 32'h00200093;
        #1;
        checks++;
        if (req0_ready_o !== 1'b1) begin
            failures++; $display("FAIL rstexec_grant: got ready0=%b expected 1", req0_ready_o);
        end
        @(negedge clk);
        req0_valid_i = 0; rst_i = 1;
        @(negedge clk);
        rst_i = 0; bad = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rsp_valid_o !== 1'b0 || rsp_we_o !== 1'b0 || rsp_wdata_o !== 32'h0 ||
                alu_inst_o !== 32'h0 || alu_op1_o !== 32'h0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL rstexec_outputs: got nonzero outputs after reset expected 0");
        end
        model_last = 1;
        transact(1, 1, 32'd4, 32'd4, 32'h00400093, 32'd5, 32'd5, 32'h00500093, 0, 0,
                 ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
        checks++;
        if (!ok || who != 0 || rid !== 1'b0 || rwd !== 32'd8) begin
            failures++;
            $display("FAIL rstexec_next: got who=%0d id=%b wd=%0d expected 0 0 8", who, rid, rwd);
        end
        model_last = 0;
        req1_valid_i = 0;
    endtask

    task automatic test_random();
        bit ok, both, busy, unst; int who, exp, stall;
        logic [31:0] e1, e2, ei, rwd; logic rv, rid, rwe;
        logic [1:0] v;
        logic [31:0] a [2], b [2], in [2];
        logic [32:0] er;
        for (int n = 0; n < 24; n++) begin
            v = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                a[r] = $urandom; b[r] = $urandom; in[r] = $urandom;
                in[r][6:0] = ($urandom_range(0, 3) != 0) ? 7'h13 : 7'h33;
                case ($urandom_range(0, 2))
                    0: in[r][31:25] = 7'h00;
                    1: in[r][31:25] = 7'h20;
                    default: in[r][31:25] = 7'h01;
                endcase
            end
            stall = $urandom_range(0, 2);
            exp = model_winner(v[0], v[1], model_last);
            er = alu_ref(a[exp], b[exp], in[exp]);
            transact(v[0], v[1], a[0], b[0], in[0], a[1], b[1], in[1], stall, 0,
                     ok, who, both, busy, unst, e1, e2, ei, rv, rid, rwe, rwd);
            model_last = exp;
            checks++;
            if (!ok || who != exp || both || busy || unst) begin
                failures++;
                $display("FAIL rand%0d_ctrl: got ok=%0d who=%0d both=%0d busy=%0d unst=%0d expected who=%0d",
                         n, ok, who, both, busy, unst, exp);
            end
            checks++;
            if (e1 !== a[exp] || e2 !== b[exp] || ei !== in[exp]) begin
                failures++;
                $display("FAIL rand%0d_exec: got %h %h %h expected %h %h %h",
                         n, e1, e2, ei, a[exp], b[exp], in[exp]);
            end
            checks++;
            if (rv !== 1'b1 || rid !== (exp == 1) || rwe !== er[32] || rwd !== er[31:0]) begin
                failures++;
                $display("FAIL rand%0d_rsp: got v=%b id=%b we=%b wd=%h expected 1 %0d %b %h",
                         n, rv, rid, rwe, rwd, exp, er[32], er[31:0]);
            end
        end
        req0_valid_i = 0; req1_valid_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1; req0_valid_i = 0; req1_valid_i = 0; rsp_ready_i = 1;
        req0_op1_i = 0; req0_op2_i = 0; req0_inst_i = 0;
        req1_op1_i = 0; req1_op2_i = 0; req1_inst_i = 0;
        test_reset();
        test_addi();
        test_srai();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
